cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control sequencer for the RV32I datapath. It fetches instructions over a req/ack instruction-memory port and holds them in an instruction register. It decodes each instruction into the datapath control bundle (PCSel, WBSel, BrUn, alu_ctrl, ASel, BSel, isWreg, register addresses, en_fetch, branch) and steps through FETCH/DECODE/EXEC/MEM/WB. It sits between the memories and the datapath, and is the only block that advances PC or writes the register file.

## Interface
- RESET_STATE_FETCH, 1: 1 means leave reset directly in FETCH; 0 means wait in IDLE for `start`.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE (used only when RESET_STATE_FETCH=0)
- imem_req / imem_ack  out / in  1 / 1  instruction fetch handshake
- imem_rdata  in  32  instruction word, sampled when imem_ack=1
- dmem_req / dmem_we / dmem_ack  out / out / in  1 / 1 / 1  data access handshake
- dmem_size  out  2  funct3[1:0] of the current load/store
- BrEq, BrLT  in  1 each  branch compare results from the datapath
- instruction  out  32  instruction register to the datapath and immediate generator
- PCSel, BSel, ASel, BrUn, isWreg, en_fetch, branch  out  1 each  datapath controls
- WBSel  out  2  0 = data_m, 1 = alu_result, 2 = PC+4
- alu_ctrl  out  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- Radd1, Radd2, Wadd  out  5 each  rs1 / rs2 / rd fields of the instruction register
- halted  out  1  sticky; set on an illegal instruction, ECALL or EBREAK
- state_o  out  3  current state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- FETCH: hold imem_req=1 until imem_ack. On ack, latch imem_rdata into instruction and go to DECODE.
- DECODE: classify the opcode and register the control bundle.
  - Illegal opcode, ECALL or EBREAK: go to HALT.
  - Otherwise: go to EXEC.
- Operand selects: ASel=1 (PC) for AUIPC, JAL and branches. BSel=1 (imm) for everything except R-type.
- alu_ctrl:
  - From funct3/funct7[5] for OP and OP-IMM. SUB only for R-type.
  - PASS_B for LUI.
  - ADD for loads, stores, AUIPC, JAL, JALR and branches (target address).
- BrUn=1 for BLTU/BGEU only.
- EXEC: sample BrEq/BrLT. Taken is evaluated per funct3:
  - BEQ=BrEq, BNE=!BrEq
  - BLT/BLTU=BrLT, BGE/BGEU=!BrLT
  - Unused branch funct3 is illegal and goes to HALT.
- EXEC next state: loads/stores go to MEM; all others go to WB.
- MEM: hold dmem_req=1 (dmem_we=1 for stores) until dmem_ack, then go to WB. alu_result is the address.
- WB: one cycle.
  - isWreg=1 for writing instructions with Wadd!=0.
  - en_fetch=1.
  - PCSel=1 for JAL, JALR and taken branches; branch=1 for a taken branch.
  - Next state is FETCH.
- WBSel: 0 for loads, 2 for JAL/JALR, 1 otherwise.
- FENCE behaves as a NOP: passes through EXEC and WB with no register write.
- HALT: all strobes are 0, halted=1. Exits only on rst.
- isWreg, en_fetch, imem_req and dmem_req are 0 in every state where not listed above.

## Timing
- Reset: state = FETCH (or IDLE), instruction = 0x00000013 (NOP), halted = 0. Every other output is 0, except Radd/Wadd, which follow the NOP fields (0).
- rst asserted in any state aborts the operation on the next edge. Outstanding req lines drop in the same cycle as the reset edge; a late ack is ignored.
- Latency with ack in the same cycle as req:
  - 4 cycles for ALU, branch and jump instructions (FETCH, DECODE, EXEC, WB).
  - 5 cycles for loads and stores.
  - Each extra wait cycle on imem or dmem adds 1 cycle.
- Handshake: req rises on entering FETCH or MEM and stays high through the ack cycle. It is low on the following cycle. Requests are never back-to-back without an intervening state.
- Control outputs are registered and stable from DECODE through WB. BrEq/BrLT are sampled only on the EXEC edge.
- en_fetch and isWreg are single-cycle pulses. They are never high outside WB.

## Test plan
- ADDI x1,x0,5 (0x00500093), ack immediate:
  - WB occurs in cycle 4 with isWreg=1, Wadd=1, WBSel=1, BSel=1, alu_ctrl=0.
  - en_fetch pulses once; PCSel=0.
- LW x2,0(x1) with dmem_ack delayed 3 cycles:
  - dmem_req is high for exactly 4 cycles with dmem_we=0, then WB with WBSel=0.
  - Total 8 cycles.
- BEQ taken (BrEq=1) and not taken (BrEq=0):
  - Taken: WB with PCSel=1, branch=1, isWreg=0.
  - Not taken: PCSel=0, branch=0.
- JAL x1,+8: WB with PCSel=1, WBSel=2, isWreg=1, ASel=1.
- Illegal word 0xFFFFFFFF, and ECALL:
  - Enter HALT; halted=1; no further imem_req for 20 cycles.
  - rst for 1 cycle clears halted and restarts FETCH.
- rst asserted mid-MEM of SW (dmem_req high):
  - Next cycle: dmem_req=0, state=FETCH.
  - A dmem_ack arriving afterwards causes no WB pulse.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an
// RV32I datapath. Fetches over a req/ack port, decodes into a registered
// control bundle, and is the only block that strobes PC update / reg write.
module cpu_sequencer #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [1:0]  dmem_size,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic [31:0] instruction,
  output logic        PCSel,
  output logic        BSel,
  output logic        ASel,
  output logic        BrUn,
  output logic        isWreg,
  output logic        en_fetch,
  output logic        branch,
  output logic [1:0]  WBSel,
  output logic [4:0]  alu_ctrl,
  output logic [4:0]  Radd1,
  output logic [4:0]  Radd2,
  output logic [4:0]  Wadd,
  output logic        halted,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_e;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2,
    ALU_SLT = 5'd3, ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6,
    ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10;

  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       writes;
    logic       asel;
    logic       bsel;
    logic       brun;
    logic [1:0] wbsel;
    logic [4:0] alu;
    logic [1:0] size;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  ctrl_t       ctrl_q, dec;
  logic        taken_q, taken_d, bad_br;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = imem_rdata[6:0];
  assign f3 = imem_rdata[14:12];
  assign f7 = imem_rdata[31:25];

  // funct3 -> ALU op; alt selects SUB/SRA
  function automatic logic [4:0] alu_of(input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_SLT;
      3'd3:    alu_of = ALU_SLTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  // Decode the incoming fetch word so the bundle is registered on the ack edge
  always_comb begin
    dec       = '0;
    dec.wbsel = 2'd1;
    case (op)
      7'b0110111: begin dec.legal = 1'b1; dec.writes = 1'b1; dec.bsel = 1'b1; dec.alu = ALU_PASSB; end
      7'b0010111: begin dec.legal = 1'b1; dec.writes = 1'b1; dec.asel = 1'b1; dec.bsel = 1'b1; end
      7'b1101111: begin
        dec.legal = 1'b1; dec.writes = 1'b1; dec.is_jump = 1'b1;
        dec.asel = 1'b1; dec.bsel = 1'b1; dec.wbsel = 2'd2;
      end
      7'b1100111: begin
        dec.legal = (f3 == 3'd0); dec.writes = 1'b1; dec.is_jump = 1'b1;
        dec.bsel = 1'b1; dec.wbsel = 2'd2;
      end
      // bad branch funct3 is caught in EXEC
      7'b1100011: begin
        dec.legal = 1'b1; dec.is_branch = 1'b1; dec.asel = 1'b1; dec.bsel = 1'b1;
        dec.brun = (f3[2:1] == 2'b11);
      end
      7'b0000011: begin
        dec.legal = (f3[1:0] != 2'd3) && !(f3[2] && f3[1]);
        dec.is_load = 1'b1; dec.writes = 1'b1; dec.bsel = 1'b1;
        dec.wbsel = 2'd0; dec.size = f3[1:0];
      end
      7'b0100011: begin
        dec.legal = !f3[2] && (f3[1:0] != 2'd3);
        dec.is_store = 1'b1; dec.bsel = 1'b1; dec.size = f3[1:0];
      end
      7'b0010011: begin
        dec.legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        dec.writes = 1'b1; dec.bsel = 1'b1;
        dec.alu = alu_of(f3, (f3 == 3'd5) && f7[5]);
      end
      7'b0110011: begin
        dec.legal  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        dec.writes = 1'b1; dec.alu = alu_of(f3, f7[5]);
      end
      7'b0001111: begin dec.legal = 1'b1; dec.bsel = 1'b1; end
      default:    dec.legal = 1'b0;
    endcase
  end

  // Branch condition from the instruction register and datapath compares
  always_comb begin
    taken_d = 1'b0;
    bad_br  = 1'b0;
    case (instr_q[14:12])
      3'd0:       taken_d = BrEq;
      3'd1:       taken_d = !BrEq;
      3'd4, 3'd6: taken_d = BrLT;
      3'd5, 3'd7: taken_d = !BrLT;
      default:    bad_br  = ctrl_q.is_branch;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
    else     state_q <= state_d;
  end

  // Instruction register, control bundle and branch outcome
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= 32'h0000_0013;
      ctrl_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) begin
        instr_q <= imem_rdata;
        ctrl_q  <= dec;
      end
      if (state_q == S_EXEC) taken_q <= taken_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = ctrl_q.legal ? S_EXEC : S_HALT;
      S_EXEC:   state_d = bad_br ? S_HALT :
                          (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Outputs: strobes decoded from state, bundle from registers
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    dmem_req  = (state_q == S_MEM);
    dmem_we   = (state_q == S_MEM) && ctrl_q.is_store;
    en_fetch  = (state_q == S_WB);
    isWreg    = (state_q == S_WB) && ctrl_q.writes && (instr_q[11:7] != 5'd0);
    branch    = (state_q == S_WB) && ctrl_q.is_branch && taken_q;
    PCSel     = (state_q == S_WB) && (ctrl_q.is_jump || (ctrl_q.is_branch && taken_q));
    halted    = (state_q == S_HALT);
    dmem_size = ctrl_q.size;
    ASel      = ctrl_q.asel;
    BSel      = ctrl_q.bsel;
    BrUn      = ctrl_q.brun;
    WBSel     = ctrl_q.wbsel;
    alu_ctrl  = ctrl_q.alu;
  end

  assign instruction = instr_q;
  assign Radd1       = instr_q[19:15];
  assign Radd2       = instr_q[24:20];
  assign Wadd        = instr_q[11:7];
  assign state_o     = state_q;

endmodule
